// File: rtl/bresenham_pkg.sv
// Shared types for the Bresenham line rasterizer: coordinate and error widths,
// FSM state encoding and an absolute-difference helper.
package bresenham_pkg;

  localparam int CoordWidth = 8;

  typedef logic [CoordWidth-1:0] coord_t;
  typedef logic [CoordWidth:0]   delta_t;
  typedef logic signed [9:0]     err_t;
  typedef logic signed [10:0]    e2_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PLOT,
    DONE
  } bla_state_t;

  function automatic delta_t absDiff(input coord_t a, input coord_t b);
    if (a >= b) begin
      return delta_t'(a - b);
    end
    return delta_t'(b - a);
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// Combinational single step of the Bresenham walker: next (cx, cy) and error term.
module bresenham_step
  import bresenham_pkg::*;
(
  input  coord_t cx_i,
  input  coord_t cy_i,
  input  err_t   err_i,
  input  delta_t dx_i,
  input  err_t   dy_i,
  input  logic   sxNeg_i,
  input  logic   syNeg_i,
  output coord_t cx_o,
  output coord_t cy_o,
  output err_t   err_o
);

  e2_t  e2;
  e2_t  dxWide;
  e2_t  dyWide;
  e2_t  errSum;
  logic stepX;
  logic stepY;

  // Both axis decisions use the pre-step error; their error updates add up.
  always_comb begin
    e2     = e2_t'(err_i) <<< 1;
    dxWide = e2_t'({2'b00, dx_i});
    dyWide = e2_t'(dy_i);
    stepX  = (e2 >= dyWide);
    stepY  = (e2 <= dxWide);
    errSum = e2_t'(err_i);
    cx_o   = cx_i;
    cy_o   = cy_i;
    if (stepX) begin
      errSum = errSum + dyWide;
      cx_o   = sxNeg_i ? cx_i - 8'd1 : cx_i + 8'd1;
    end
    if (stepY) begin
      errSum = errSum + dxWide;
      cy_o   = syNeg_i ? cy_i - 8'd1 : cy_i + 8'd1;
    end
    err_o = err_t'(errSum);
  end

endmodule

// File: rtl/bresenham_line_drawer.sv
// Bresenham line rasterizer: one segment per draw_en, pixels out on a valid/ready stream.
// Optional BRESENHAM_PIXEL_CNT_EN adds a pixel_cnt output counting accepted pixels.
module bresenham_line_drawer
  import bresenham_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       draw_en,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic       pixel_ready,
  output logic       pixel_valid,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y,
  output logic       busy,
`ifdef BRESENHAM_PIXEL_CNT_EN
  output logic [8:0] pixel_cnt,
`endif
  output logic       draw_done
);

  bla_state_t state_q;
  coord_t     cx_q;
  coord_t     cy_q;
  coord_t     x1_q;
  coord_t     y1_q;
  delta_t     dx_q;
  err_t       dy_q;
  err_t       err_q;
  logic       sxNeg_q;
  logic       syNeg_q;
  logic       pixelValid_q;
  logic       drawDone_q;
`ifdef BRESENHAM_PIXEL_CNT_EN
  logic [8:0] pixelCnt_q;
`endif

  coord_t cx_d;
  coord_t cy_d;
  err_t   err_d;

  delta_t dxSetup;
  delta_t adySetup;
  err_t   dySetup;
  err_t   errSetup;

  // The start point is latched straight into (cx, cy), so SETUP derives the
  // line parameters from the current point and the latched end point.
  always_comb begin
    dxSetup  = absDiff(cx_q, x1_q);
    adySetup = absDiff(cy_q, y1_q);
    dySetup  = -err_t'(adySetup);
    errSetup = err_t'(dxSetup) + dySetup;
  end

  bresenham_step u_step (
    .cx_i    (cx_q),
    .cy_i    (cy_q),
    .err_i   (err_q),
    .dx_i    (dx_q),
    .dy_i    (dy_q),
    .sxNeg_i (sxNeg_q),
    .syNeg_i (syNeg_q),
    .cx_o    (cx_d),
    .cy_o    (cy_d),
    .err_o   (err_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      sxNeg_q      <= 1'b0;
      syNeg_q      <= 1'b0;
      pixelValid_q <= 1'b0;
      drawDone_q   <= 1'b0;
`ifdef BRESENHAM_PIXEL_CNT_EN
      pixelCnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (draw_en) begin
            cx_q    <= x0;
            cy_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          dx_q         <= dxSetup;
          dy_q         <= dySetup;
          err_q        <= errSetup;
          sxNeg_q      <= !(cx_q < x1_q);
          syNeg_q      <= !(cy_q < y1_q);
          pixelValid_q <= 1'b1;
`ifdef BRESENHAM_PIXEL_CNT_EN
          pixelCnt_q   <= '0;
`endif
          state_q      <= PLOT;
        end
        PLOT: begin
          if (pixel_ready) begin
`ifdef BRESENHAM_PIXEL_CNT_EN
            pixelCnt_q <= pixelCnt_q + 9'd1;
`endif
            if (cx_q == x1_q && cy_q == y1_q) begin
              pixelValid_q <= 1'b0;
              drawDone_q   <= 1'b1;
              state_q      <= DONE;
            end else begin
              cx_q  <= cx_d;
              cy_q  <= cy_d;
              err_q <= err_d;
            end
          end
        end
        DONE: begin
          drawDone_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          pixelValid_q <= 1'b0;
          drawDone_q   <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign pixel_valid = pixelValid_q;
  assign pixel_x     = cx_q;
  assign pixel_y     = cy_q;
  assign busy        = (state_q != IDLE);
  assign draw_done   = drawDone_q;
`ifdef BRESENHAM_PIXEL_CNT_EN
  assign pixel_cnt   = pixelCnt_q;
`endif

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Self-checking bench for bresenham_line_drawer: directed test-plan lines plus
// random segments compared against a behavioural pixel-list model.
module tb_bresenham_line_drawer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       draw_en;
  logic [7:0] x0, y0, x1, y1;
  logic       pixel_ready;
  logic       pixel_valid;
  logic [7:0] pixel_x, pixel_y;
  logic       busy;
  logic       draw_done;
`ifdef BRESENHAM_PIXEL_CNT_EN
  logic [8:0] pixel_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int expX[$];
  int expY[$];

  always #5 clk = ~clk;

  bresenham_line_drawer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .draw_en     (draw_en),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .pixel_ready (pixel_ready),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .busy        (busy),
`ifdef BRESENHAM_PIXEL_CNT_EN
    .pixel_cnt   (pixel_cnt),
`endif
    .draw_done   (draw_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference pixel list: textbook integer Bresenham on unbounded ints.
  task automatic buildModel(input int ax0, input int ay0, input int ax1, input int ay1);
    int x, y, ddx, ddy, sx, sy, err, e2;
    expX.delete();
    expY.delete();
    ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ddy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    x   = ax0;
    y   = ay0;
    err = ddx + ddy;
    for (int k = 0; k < 1024; k++) begin
      expX.push_back(x);
      expY.push_back(y);
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= ddy) begin
        err += ddy;
        x   += sx;
      end
      if (e2 <= ddx) begin
        err += ddx;
        y   += sy;
      end
    end
  endtask

  // Pulses draw_en for one cycle, then scrambles the endpoint inputs.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
    x0 = 8'(ax0);
    y0 = 8'(ay0);
    x1 = 8'(ax1);
    y1 = 8'(ay1);
    draw_en = 1'b1;
    tick();
    draw_en = 1'b0;
    x0 = 8'($urandom);
    y0 = 8'($urandom);
    x1 = 8'($urandom);
    y1 = 8'($urandom);
  endtask

  // stallMode: 0 = ready held high, 1 = random stalls, 2 = three stall cycles at pixel 1.
  task automatic runLine(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int stallMode, input bit noise, output int accepted);
    int idx, firstValid, doneCyc, budget, stalls, stallLeft, adx, ady, wantCount;
    bit seenDone;
    buildModel(ax0, ay0, ax1, ay1);
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    wantCount = ((adx > ady) ? adx : ady) + 1;
    idx = 0; firstValid = -1; doneCyc = -1; stalls = 0; stallLeft = 3; seenDone = 1'b0;
    budget = 8 * wantCount + 20;
    pixel_ready = 1'b1;
    applyStimulus(ax0, ay0, ax1, ay1);
    checkOutput("setupBusy", 32'(busy), 1);
    checkOutput("setupValid", 32'(pixel_valid), 0);
    tick();
    for (int cyc = 2; cyc <= budget && !seenDone; cyc++) begin
      if (stallMode == 1) begin
        pixel_ready = ($urandom_range(0, 3) != 0);
      end else if (stallMode == 2 && idx == 1 && stallLeft > 0 && pixel_valid === 1'b1) begin
        pixel_ready = 1'b0;
        stallLeft--;
      end else begin
        pixel_ready = 1'b1;
      end
      if (pixel_valid === 1'b1) begin
        if (firstValid < 0) firstValid = cyc;
        if (idx < expX.size()) begin
          checkOutput("pixelX", 32'(pixel_x), expX[idx]);
          checkOutput("pixelY", 32'(pixel_y), expY[idx]);
        end else begin
          checkOutput("extraPixel", idx, expX.size() - 1);
        end
        if (pixel_ready) idx++;
        else stalls++;
      end
      if (draw_done === 1'b1) begin
        seenDone = 1'b1;
        doneCyc  = cyc;
        checkOutput("doneWithValid", 32'(pixel_valid), 0);
        if (noise) begin
          draw_en = 1'b1;
          x0 = 8'($urandom);
          y1 = 8'($urandom);
        end
      end else if (noise && busy === 1'b1 && $urandom_range(0, 7) == 0) begin
        draw_en = 1'b1;
        x1 = 8'($urandom);
        y0 = 8'($urandom);
      end
      tick();
      draw_en = 1'b0;
    end
    if (!seenDone) begin
      checkOutput("timeoutDone", 32'(seenDone), 1);
      n_rst = 1'b0;
      #2;
      n_rst = 1'b1;
      tick();
    end else begin
      checkOutput("pixelCount", idx, wantCount);
      checkOutput("firstValidCycle", firstValid, 2);
      checkOutput("doneCycle", doneCyc, wantCount + 2 + stalls);
      checkOutput("idleBusy", 32'(busy), 0);
      checkOutput("idleDone", 32'(draw_done), 0);
`ifdef BRESENHAM_PIXEL_CNT_EN
      checkOutput("pixelCnt", 32'(pixel_cnt), wantCount);
`endif
    end
    accepted = idx;
  endtask

  initial begin
    int n, bx, by;
    n_rst = 1'b0;
    draw_en = 1'b0;
    pixel_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) tick();
    checkOutput("rstValid", 32'(pixel_valid), 0);
    checkOutput("rstX", 32'(pixel_x), 0);
    checkOutput("rstY", 32'(pixel_y), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(draw_done), 0);
    n_rst = 1'b1;
    tick();

    runLine(0, 0, 3, 0, 0, 1'b0, n);
    checkOutput("hLineCount", n, 4);
    runLine(3, 1, 0, 3, 0, 1'b0, n);
    checkOutput("octantCount", n, 4);
    runLine(0, 0, 255, 255, 0, 1'b0, n);
    checkOutput("diagCount", n, 256);
    checkOutput("diagLastX", 32'(pixel_x), 255);
    checkOutput("diagLastY", 32'(pixel_y), 255);
    runLine(5, 5, 5, 5, 0, 1'b0, n);
    checkOutput("pointCount", n, 1);
    runLine(10, 20, 14, 18, 2, 1'b0, n);
    checkOutput("stallCount", n, 5);
    runLine(200, 10, 30, 90, 1, 1'b1, n);

    pixel_ready = 1'b1;
    applyStimulus(0, 0, 200, 100);
    repeat (10) tick();
    checkOutput("preResetValid", 32'(pixel_valid), 1);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("abortValid", 32'(pixel_valid), 0);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortDone", 32'(draw_done), 0);
    tick();
    checkOutput("abortDoneLater", 32'(draw_done), 0);
    n_rst = 1'b1;
    tick();
    runLine(7, 9, 2, 30, 0, 1'b0, n);

    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) begin
        bx = $urandom_range(16, 239);
        by = $urandom_range(16, 239);
        runLine(bx, by, bx + $urandom_range(0, 30) - 15, by + $urandom_range(0, 30) - 15,
                $urandom_range(0, 1), 1'($urandom_range(0, 1)), n);
      end else begin
        runLine($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 1), 1'($urandom_range(0, 1)), n);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
